// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use interlock, EX mispredict recovery,
// ID jump squash and multi-cycle mult/div stall, plus free-running stall/flush event counters.
module pipeline_hazard_ctrl #(
  parameter int MD_LAT = 8,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs_ID,
  input  logic [4:0]       Rt_ID,
  input  logic             UseRs_ID,
  input  logic             UseRt_ID,
  input  logic             Jump_ID,
  input  logic [4:0]       Rt_Ex,
  input  logic             MemToReg_Ex,
  input  logic             RegWr_Ex,
  input  logic             Branch_Ex,
  input  logic             BranchPredict_Ex,
  input  logic             BranchTaken_Ex,
  input  logic             MdStart_Ex,
  output logic             stall_PC,
  output logic             pc_redirect,
  output logic             stall_IF_ID,
  output logic             flush_IF_ID,
  output logic             stall_ID_EX,
  output logic             flush_ID_EX,
  output logic             flush_EX_MEM,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int MD_W = $clog2(MD_LAT + 1);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MD_BUSY = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use, mispredict, md_entry, md_last;

  assign load_use = MemToReg_Ex && RegWr_Ex && (Rt_Ex != 5'd0) &&
                    ((UseRs_ID && (Rs_ID == Rt_Ex)) || (UseRt_ID && (Rt_ID == Rt_Ex)));
  assign mispredict = Branch_Ex && (BranchTaken_Ex != BranchPredict_Ex);
  assign md_entry   = (state_q == IDLE) && MdStart_Ex && !mispredict;
  assign md_last    = (state_q == MD_BUSY) && (md_cnt_q == MD_W'(1));

  // NOTE: every output gets a default before the priority chain so no latch is inferred.
  always_comb begin
    stall_PC     = 1'b0;
    pc_redirect  = 1'b0;
    stall_IF_ID  = 1'b0;
    flush_IF_ID  = 1'b0;
    stall_ID_EX  = 1'b0;
    flush_ID_EX  = 1'b0;
    flush_EX_MEM = 1'b0;
    md_busy      = 1'b0;
    if (rst) begin
      // all outputs held low during reset
    end else if (state_q == MD_BUSY) begin
      // last busy cycle is silent so the mult/div result advances out of EX
      if (!md_last) begin
        stall_PC     = 1'b1;
        stall_IF_ID  = 1'b1;
        stall_ID_EX  = 1'b1;
        flush_EX_MEM = 1'b1;
        md_busy      = 1'b1;
      end
    end else if (mispredict) begin
      pc_redirect = 1'b1;
      flush_IF_ID = 1'b1;
      flush_ID_EX = 1'b1;
    end else if (md_entry) begin
      stall_PC     = 1'b1;
      stall_IF_ID  = 1'b1;
      stall_ID_EX  = 1'b1;
      flush_EX_MEM = 1'b1;
      md_busy      = 1'b1;
    end else if (load_use) begin
      stall_PC    = 1'b1;
      stall_IF_ID = 1'b1;
      flush_ID_EX = 1'b1;
    end else if (Jump_ID) begin
      flush_IF_ID = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    if (state_q == IDLE) begin
      if (md_entry) begin
        state_d  = MD_BUSY;
        md_cnt_d = MD_W'(MD_LAT - 1);
      end
    end else begin
      md_cnt_d = md_cnt_q - MD_W'(1);
      if (md_last) state_d = IDLE;
    end
  end

  assign stall_cnt_d = stall_cnt_q + CNT_W'(stall_PC);
  assign flush_cnt_d = flush_cnt_q +
                       CNT_W'(flush_IF_ID || flush_ID_EX || flush_EX_MEM);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl; expected output codes and counter values are
// worked out by hand for each vector.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Rs_ID, Rt_ID, Rt_Ex;
  logic        UseRs_ID, UseRt_ID, Jump_ID;
  logic        MemToReg_Ex, RegWr_Ex, Branch_Ex, BranchPredict_Ex, BranchTaken_Ex, MdStart_Ex;
  logic        stall_PC, pc_redirect, stall_IF_ID, flush_IF_ID;
  logic        stall_ID_EX, flush_ID_EX, flush_EX_MEM, md_busy;
  logic [31:0] stall_cnt, flush_cnt;

  int vectors = 0;
  int miscompares = 0;

  // {stall_PC, pc_redirect, stall_IF_ID, flush_IF_ID, stall_ID_EX, flush_ID_EX, flush_EX_MEM, md_busy}
  logic [7:0] outs;
  assign outs = {stall_PC, pc_redirect, stall_IF_ID, flush_IF_ID,
                 stall_ID_EX, flush_ID_EX, flush_EX_MEM, md_busy};

  localparam logic [7:0] O_NONE = 8'h00;
  localparam logic [7:0] O_LU   = 8'hA4;
  localparam logic [7:0] O_MISP = 8'h54;
  localparam logic [7:0] O_MD   = 8'hAB;
  localparam logic [7:0] O_JMP  = 8'h10;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MD_LAT(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .UseRs_ID(UseRs_ID), .UseRt_ID(UseRt_ID), .Jump_ID(Jump_ID),
    .Rt_Ex(Rt_Ex), .MemToReg_Ex(MemToReg_Ex), .RegWr_Ex(RegWr_Ex), .Branch_Ex(Branch_Ex),
    .BranchPredict_Ex(BranchPredict_Ex), .BranchTaken_Ex(BranchTaken_Ex), .MdStart_Ex(MdStart_Ex),
    .stall_PC(stall_PC), .pc_redirect(pc_redirect), .stall_IF_ID(stall_IF_ID),
    .flush_IF_ID(flush_IF_ID), .stall_ID_EX(stall_ID_EX), .flush_ID_EX(flush_ID_EX),
    .flush_EX_MEM(flush_EX_MEM), .md_busy(md_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    Rs_ID = 5'd0; Rt_ID = 5'd0; UseRs_ID = 1'b0; UseRt_ID = 1'b0; Jump_ID = 1'b0;
    Rt_Ex = 5'd0; MemToReg_Ex = 1'b0; RegWr_Ex = 1'b0; Branch_Ex = 1'b0;
    BranchPredict_Ex = 1'b0; BranchTaken_Ex = 1'b0; MdStart_Ex = 1'b0;
  endtask

  // lw $r in EX, ID instruction reads $r through rs
  task automatic set_load_use(input logic [4:0] r);
    Rt_Ex = r; MemToReg_Ex = 1'b1; RegWr_Ex = 1'b1; Rs_ID = r; UseRs_ID = 1'b1;
  endtask

  // inputs are already applied; check combinational outputs, then move to the next negedge
  task automatic vec(input string tag, input logic [7:0] exp);
    #1;
    check(tag, {24'd0, outs}, {24'd0, exp});
    @(negedge clk);
  endtask

  task automatic cnts(input string tag, input logic [31:0] s, input logic [31:0] f);
    check({tag, "_stall_cnt"}, stall_cnt, s);
    check({tag, "_flush_cnt"}, flush_cnt, f);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    set_load_use(5'd2);
    @(negedge clk);
    vec("rst_outs_low", O_NONE);
    cnts("after_rst", 32'd0, 32'd0);
    rst = 1'b0;
    clear_inputs();
    vec("idle", O_NONE);

    // load-use through rs, one bubble
    set_load_use(5'd2);
    vec("lu_rs", O_LU);
    cnts("lu_rs", 32'd1, 32'd1);
    clear_inputs();
    vec("lu_resolved", O_NONE);

    // load-use through rt
    Rt_Ex = 5'd5; MemToReg_Ex = 1'b1; RegWr_Ex = 1'b1; Rt_ID = 5'd5; UseRt_ID = 1'b1;
    vec("lu_rt", O_LU);
    cnts("lu_rt", 32'd2, 32'd2);

    // $0 destination never interlocks
    clear_inputs(); set_load_use(5'd0);
    vec("lu_r0", O_NONE);
    // matching register but not read
    clear_inputs(); set_load_use(5'd7); UseRs_ID = 1'b0;
    vec("lu_unused", O_NONE);
    // non-load producer does not interlock
    clear_inputs(); set_load_use(5'd7); MemToReg_Ex = 1'b0;
    vec("lu_not_load", O_NONE);
    cnts("no_lu", 32'd2, 32'd2);

    // mispredict beats load-use
    clear_inputs(); set_load_use(5'd3);
    Branch_Ex = 1'b1; BranchPredict_Ex = 1'b0; BranchTaken_Ex = 1'b1;
    vec("misp_over_lu", O_MISP);
    cnts("misp", 32'd2, 32'd3);
    clear_inputs();
    Branch_Ex = 1'b1; BranchPredict_Ex = 1'b1; BranchTaken_Ex = 1'b1;
    vec("branch_ok", O_NONE);

    // jump held under load-use, squash issued after release
    clear_inputs(); set_load_use(5'd4); Jump_ID = 1'b1;
    vec("jump_under_lu", O_LU);
    MemToReg_Ex = 1'b0;
    vec("jump_after_lu", O_JMP);
    cnts("jump", 32'd3, 32'd5);

    // mult/div, MD_LAT=8: 7 stall cycles then one silent cycle
    clear_inputs(); MdStart_Ex = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) set_load_use(5'd9);  // load-use suppressed while busy
      vec($sformatf("md_stall_%0d", i), O_MD);
    end
    vec("md_last", O_NONE);
    clear_inputs();
    vec("md_done", O_NONE);
    cnts("md", 32'd10, 32'd12);

    // mispredict blocks mult/div entry
    MdStart_Ex = 1'b1; Branch_Ex = 1'b1; BranchPredict_Ex = 1'b1; BranchTaken_Ex = 1'b0;
    vec("misp_over_md", O_MISP);
    clear_inputs();
    vec("md_not_entered", O_NONE);
    cnts("misp_md", 32'd10, 32'd13);

    // reset on 3rd MD_BUSY cycle
    MdStart_Ex = 1'b1;
    vec("md2_entry", O_MD);
    vec("md2_busy1", O_MD);
    vec("md2_busy2", O_MD);
    rst = 1'b1;
    vec("md2_rst", O_NONE);
    rst = 1'b0; MdStart_Ex = 1'b0;
    vec("md2_idle", O_NONE);
    cnts("md2_rst", 32'd0, 32'd0);

    // fresh mult/div after reset runs full length
    MdStart_Ex = 1'b1;
    for (int i = 0; i < 7; i++) vec($sformatf("md3_stall_%0d", i), O_MD);
    vec("md3_last", O_NONE);
    clear_inputs();
    cnts("md3", 32'd7, 32'd7);

    // stall counter wrap
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    check("preload", stall_cnt, 32'hFFFF_FFFF);
    set_load_use(5'd6);
    vec("wrap_lu", O_LU);
    check("wrap_stall_cnt", stall_cnt, 32'd0);
    check("wrap_flush_cnt", flush_cnt, 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
